// File: rtl/f2i_arbiter.sv
// f2i_arbiter: round-robin front end sharing one float-to-int converter among NREQ requesters
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   req_valid_i[NREQ]      per-requester request valid
//   req_float_i[32*NREQ]   IEEE-754 single operands, requester i at [32i+31:32i]
//   req_ready_o[NREQ]      one-hot accept to the granted requester
//   out_valid_o/out_ready_i  result register handshake
//   out_int_o, out_id_o    converted integer and the requester that issued it
//   out_plost_o, out_denorm_o, out_invalid_o  per-result converter flags
//   flags_clr_i            clears sticky flags and the invalid counter
//   sticky_*_o             OR of result flags since the last clear
//   invalid_cnt_o          saturating count of invalid conversions
module f2i_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [32*NREQ-1:0] req_float_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_int_o,
    output logic [IDW-1:0]    out_id_o,
    output logic              out_plost_o,
    output logic              out_denorm_o,
    output logic              out_invalid_o,
    input  logic              flags_clr_i,
    output logic              sticky_plost_o,
    output logic              sticky_denorm_o,
    output logic              sticky_invalid_o,
    output logic [CNTW-1:0]   invalid_cnt_o
);
    logic [IDW-1:0]  rr_q, rr_d, g;
    logic            hit, can_load, accept;
    logic [31:0]     op;
    logic            s;
    logic [7:0]      e, sh;
    logic [22:0]     m;
    logic [54:0]     shifted;
    logic [31:0]     c_int;
    logic            c_pl, c_dn, c_inv;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_int_q, out_int_d;
    logic [IDW-1:0]  out_id_q, out_id_d;
    logic [2:0]      out_fl_q, out_fl_d;
    logic [2:0]      sticky_q, sticky_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_base;

    // Scan from rr upward with wrap; iterating from the far end lets the
    // closest valid index to rr win.
    always_comb begin
        int j;
        j   = 0;
        hit = 1'b0;
        g   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(rr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req_valid_i[j]) begin
                hit = 1'b1;
                g   = IDW'(j);
            end
        end
    end

    always_comb begin
        op = '0;
        for (int k = 0; k < NREQ; k++)
            if (IDW'(k) == g) op = req_float_i[32*k +: 32];
    end

    assign can_load    = !out_valid_q || out_ready_i;
    assign accept      = hit && can_load;
    // Held low during reset so no requester sees an accept that cannot land.
    assign req_ready_o = (accept && rst_ni) ? (NREQ'(1) << g) : '0;
    assign rr_d        = accept ? ((int'(g) == NREQ - 1) ? '0 : g + 1'b1) : rr_q;

    // float2int, truncating toward zero
    assign s       = op[31];
    assign e       = op[30:23];
    assign m       = op[22:0];
    assign sh      = e - 8'd127;
    // Integer part lands in [54:23], discarded fraction in [22:0].
    assign shifted = {31'b0, 1'b1, m} << sh;

    always_comb begin
        c_int = '0;
        c_pl  = 1'b0;
        c_dn  = 1'b0;
        c_inv = 1'b0;
        if (e == 8'd0) begin
            c_dn = |m;
            c_pl = |m;
        end else if (e >= 8'd158) begin
            // Only exactly -2^31 is representable at or above 2^31.
            c_int = 32'h8000_0000;
            c_inv = !(e == 8'd158 && s && m == '0);
        end else if (e < 8'd127) begin
            c_pl = 1'b1;
        end else begin
            c_int = s ? -shifted[54:23] : shifted[54:23];
            c_pl  = |shifted[22:0];
        end
    end

    always_comb begin
        out_valid_d = accept || (out_valid_q && !out_ready_i);
        out_int_d   = accept ? c_int : out_int_q;
        out_id_d    = accept ? g : out_id_q;
        out_fl_d    = accept ? {c_pl, c_dn, c_inv} : out_fl_q;
        // A clear coinciding with an accept keeps only that accept's flags.
        sticky_d    = (flags_clr_i ? 3'b000 : sticky_q) | (accept ? {c_pl, c_dn, c_inv} : 3'b000);
        cnt_base    = flags_clr_i ? '0 : cnt_q;
        cnt_d       = (accept && c_inv && !(&cnt_base)) ? cnt_base + 1'b1 : cnt_base;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_int_q   <= '0;
            out_id_q    <= '0;
            out_fl_q    <= '0;
            sticky_q    <= '0;
            cnt_q       <= '0;
        end else begin
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_int_q   <= out_int_d;
            out_id_q    <= out_id_d;
            out_fl_q    <= out_fl_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid_o      = out_valid_q;
    assign out_int_o        = out_int_q;
    assign out_id_o         = out_id_q;
    assign out_plost_o      = out_fl_q[2];
    assign out_denorm_o     = out_fl_q[1];
    assign out_invalid_o    = out_fl_q[0];
    assign sticky_plost_o   = sticky_q[2];
    assign sticky_denorm_o  = sticky_q[1];
    assign sticky_invalid_o = sticky_q[0];
    assign invalid_cnt_o    = cnt_q;
endmodule

// File: tb/tb_f2i_arbiter.sv
// tb_f2i_arbiter: directed scoreboard bench for f2i_arbiter
//
// Ports: none (top-level bench). Stimulus pushes hand-computed results into a
// queue; a negedge monitor pops and compares on every output handshake.
module tb_f2i_arbiter;
    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] v;
        logic [2:0]  f;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_float;
    logic [3:0]   req_ready;
    logic         out_valid, out_ready;
    logic [31:0]  out_int;
    logic [1:0]   out_id;
    logic         out_plost, out_denorm, out_invalid;
    logic         flags_clr;
    logic         st_pl, st_dn, st_inv;
    logic [15:0]  cnt;

    logic [31:0]  op_f[4];
    logic [31:0]  op_i[4];
    logic [2:0]   op_fl[4];
    exp_t         sb[$];
    exp_t         mon_e;
    int           ntests = 0;
    int           nfail = 0;

    assign req_float = {op_f[3], op_f[2], op_f[1], op_f[0]};

    always #5 clk = ~clk;

    f2i_arbiter #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_float_i(req_float), .req_ready_o(req_ready),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_int_o(out_int), .out_id_o(out_id),
        .out_plost_o(out_plost), .out_denorm_o(out_denorm), .out_invalid_o(out_invalid),
        .flags_clr_i(flags_clr),
        .sticky_plost_o(st_pl), .sticky_denorm_o(st_dn), .sticky_invalid_o(st_inv),
        .invalid_cnt_o(cnt)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        ntests++;
        if (a !== x) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", n, a, x);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] f, input logic [31:0] v, input logic [2:0] fl);
        op_f[i]  = f;
        op_i[i]  = v;
        op_fl[i] = fl;
    endtask

    // One cycle: drive, check grant at negedge, queue expected result, step past the edge.
    task automatic cyc(input logic [3:0] v, input logic [3:0] er, input logic ordy, input logic clr);
        req_valid = v;
        out_ready = ordy;
        flags_clr = clr;
        @(negedge clk);
        chk("req_ready", {28'b0, req_ready}, {28'b0, er});
        for (int k = 0; k < 4; k++)
            if (er[k]) sb.push_back({2'(k), op_i[k], op_fl[k]});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sticky(input string n, input logic [2:0] x, input logic [15:0] c);
        chk({n, "_sticky"}, {29'b0, st_pl, st_dn, st_inv}, {29'b0, x});
        chk({n, "_cnt"}, {16'b0, cnt}, {16'b0, c});
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", {30'b0, out_id}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("out_int", out_int, mon_e.v);
                chk("out_id", {30'b0, out_id}, {30'b0, mon_e.id});
                chk("out_flags", {29'b0, out_plost, out_denorm, out_invalid}, {29'b0, mon_e.f});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) set_op(k, 32'h0, 32'h0, 3'b000);
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b0;
        flags_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_int", out_int, 32'h0);
        chk("rst_ready", {28'b0, req_ready}, 32'h0);
        chk_sticky("rst", 3'b000, 16'd0);
        req_valid = 4'b0000;
        rst_n     = 1'b1;

        // 1.0 from requester 2
        set_op(2, 32'h3F80_0000, 32'd1, 3'b000);
        cyc(4'b0100, 4'b0100, 1, 0);
        cyc(4'b0000, 4'b0000, 1, 0);
        chk_sticky("one", 3'b000, 16'd0);

        // -2.5 truncates to -2 with precision lost
        set_op(0, 32'hC020_0000, 32'hFFFF_FFFE, 3'b100);
        cyc(4'b0001, 4'b0001, 1, 0);
        cyc(4'b0000, 4'b0000, 1, 0);
        chk_sticky("neg", 3'b100, 16'd0);
        cyc(4'b0000, 4'b0000, 1, 0);
        chk_sticky("neg_hold", 3'b100, 16'd0);

        // +2^31 and +inf are invalid
        set_op(1, 32'h4F00_0000, 32'h8000_0000, 3'b001);
        cyc(4'b0010, 4'b0010, 1, 0);
        set_op(1, 32'h7F80_0000, 32'h8000_0000, 3'b001);
        cyc(4'b0010, 4'b0010, 1, 0);
        cyc(4'b0000, 4'b0000, 1, 0);
        chk_sticky("inv2", 3'b101, 16'd2);
        cyc(4'b0000, 4'b0000, 1, 1);
        chk_sticky("clr", 3'b000, 16'd0);

        // -2^31 exact, largest finite below 2^31, and -0: all clean
        set_op(2, 32'hCF00_0000, 32'h8000_0000, 3'b000);
        set_op(3, 32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000);
        cyc(4'b1100, 4'b0100, 1, 0);
        cyc(4'b1000, 4'b1000, 1, 0);
        set_op(0, 32'h8000_0000, 32'h0, 3'b000);
        cyc(4'b0001, 4'b0001, 1, 0);
        cyc(4'b0000, 4'b0000, 1, 0);
        chk_sticky("bound", 3'b000, 16'd0);

        // bring rr to 0, then all four contend
        set_op(3, 32'h4040_0000, 32'd3, 3'b000);
        cyc(4'b1000, 4'b1000, 1, 0);
        set_op(0, 32'h3F80_0000, 32'd1, 3'b000);
        set_op(1, 32'h4000_0000, 32'd2, 3'b000);
        set_op(2, 32'h40A0_0000, 32'd5, 3'b000);
        set_op(3, 32'hBF00_0000, 32'd0, 3'b100);
        cyc(4'b1111, 4'b0001, 1, 0);
        cyc(4'b1111, 4'b0010, 1, 0);
        cyc(4'b1111, 4'b0100, 1, 0);
        cyc(4'b1111, 4'b1000, 1, 0);
        cyc(4'b1111, 4'b0001, 1, 0);
        cyc(4'b1111, 4'b0010, 1, 0);
        cyc(4'b0000, 4'b0000, 1, 0);

        // backpressure: result frozen, then pop and load on one edge
        cyc(4'b1100, 4'b0100, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(4'b1100, 4'b0000, 0, 0);
            chk("hold_int", out_int, 32'd5);
            chk("hold_id", {30'b0, out_id}, 32'd2);
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
        end
        cyc(4'b1100, 4'b1000, 1, 0);
        chk("swap_id", {30'b0, out_id}, 32'd3);
        chk("swap_valid", {31'b0, out_valid}, 32'd1);
        cyc(4'b0000, 4'b0000, 1, 0);
        cyc(4'b0000, 4'b0000, 1, 0);
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // -inf invalid, then clear coinciding with accepts
        set_op(0, 32'hFF80_0000, 32'h8000_0000, 3'b001);
        cyc(4'b0001, 4'b0001, 1, 0);
        chk_sticky("ninf", 3'b101, 16'd1);
        set_op(0, 32'h0000_0001, 32'h0, 3'b110);
        cyc(4'b0001, 4'b0001, 1, 1);
        chk_sticky("clr_dn", 3'b110, 16'd0);
        set_op(1, 32'hCF00_0001, 32'h8000_0000, 3'b001);
        cyc(4'b0010, 4'b0010, 1, 1);
        chk_sticky("clr_inv", 3'b001, 16'd1);
        cyc(4'b0000, 4'b0000, 1, 0);

        // reset while a result is held
        set_op(2, 32'h40A0_0000, 32'd5, 3'b000);
        cyc(4'b0100, 4'b0100, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'b0, out_valid}, 32'h0);
        chk("mrst_int", out_int, 32'h0);
        chk("mrst_id", {30'b0, out_id}, 32'h0);
        chk("mrst_ready", {28'b0, req_ready}, 32'h0);
        chk_sticky("mrst", 3'b000, 16'd0);
        sb.delete();
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_op(3, 32'h4000_0000, 32'd2, 3'b000);
        cyc(4'b1100, 4'b0100, 1, 0);
        cyc(4'b0000, 4'b0000, 1, 0);
        chk("sb_drain", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/f2i_arbiter.md
# f2i_arbiter

Shares one `float2int` conversion datapath among `NREQ` requesters. Requests are granted round-robin, and each accepted operand is converted in one cycle. The result is held in a one-entry output register with a valid/ready handshake and tagged with the requester ID. Sticky exception flags and a saturating invalid-event counter accumulate per accepted conversion, giving the FPU status path a single, sequenced converter front end.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `IDW`, 2, requester-ID width; must equal ceil(log2(NREQ))
- `CNTW`, 16, invalid-event counter width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `req_valid`  in  NREQ  per-requester request valid
- `req_float`  in  32*NREQ  IEEE-754 single operands; requester i uses bits [32i+31:32i]
- `req_ready`  out  NREQ  per-requester accept; at most one bit high
- `out_valid`  out  1  result register holds a result
- `out_ready`  in  1  downstream accepts the result
- `out_int`  out  32  converted signed integer
- `out_id`  out  IDW  requester that issued the result
- `out_plost`, `out_denorm`, `out_invalid`  out  1 each  per-result flags from the converter
- `flags_clr`  in  1  clears the sticky flags and the counter
- `sticky_plost`, `sticky_denorm`, `sticky_invalid`  out  1 each  OR of flags since the last clear
- `invalid_cnt`  out  CNTW  count of invalid conversions; saturates at all-ones

## Operation
- Conversion: operand → `float2int` (combinational) → output register.
  - Truncates toward zero.
  - Out-of-range input, including +2^31 and any exponent above 158: `int`=0x80000000, invalid=1, plost=0.
  - Denormal input: `int`=0, denorm=1, plost=1.
  - ±0: `int`=0, no flags.
  - Magnitude <1: `int`=0, plost=1.
- Arbiter: round-robin over `req_valid`. A pointer `rr` (IDW bits) marks the highest-priority index. Scan starts at `rr` and moves upward with wrap. The grant is combinational.
- `can_load` = !`out_valid` | `out_ready`.
- `req_ready[g]` = `can_load` & `req_valid[g]` for the granted index g. All other bits are 0.
- Accept = any `req_ready` bit high. On accept:
  - Load `out_int`, `out_id`=g, and the three per-result flags.
  - Set `out_valid`.
  - Set `rr` to (g+1) mod NREQ.
- No accept this cycle:
  - If `out_ready` & `out_valid`, clear `out_valid`.
  - `rr` is unchanged.
- Sticky flags and counter on accept:
  - sticky_x |= result flag x.
  - `invalid_cnt` increments on invalid=1 and holds at 2^CNTW-1.
- `flags_clr`:
  - Without an accept in the same cycle: all sticky flags go to 0 and the counter goes to 0.
  - With an accept in the same cycle: the result is the new accept's flags alone, and the counter becomes 0 or 1.
- Requesters must hold `req_valid` and the operand until they see `req_ready`. The block does not cancel or reorder requests.

## Timing
- Reset (`rst_n`=0, async): `out_valid`=0, `out_int`=0, `out_id`=0, all flags 0, `invalid_cnt`=0, `rr`=0, `req_ready`=0.
- Reset mid-transfer discards the held result. No partial state survives.
- Latency: accept at edge N; the result is visible on `out_valid` and the data outputs after edge N.
- Throughput: one result per cycle while `out_ready`=1.
- Full, `out_ready`=0: `req_ready`=0. The result and all outputs are stable until taken.
- Simultaneous `out_ready`=1 and a new request: the old result leaves and the new one loads on the same edge, with no bubble.
- Empty, no `req_valid`: `out_valid` falls after the last pop.
- Single requester: it is granted every cycle regardless of `rr`.
- `rr` wrap: after grant NREQ-1, `rr`=0.

## Test plan
- Single request 0x3F800000 from requester 2 with `out_ready`=1. Expect `req_ready`=0b0100, then next cycle `out_int`=1, `out_id`=2, no flags.
- 0xC0200000 (-2.5). Expect `out_int`=0xFFFFFFFE, `out_plost`=1, and `sticky_plost`=1 persisting afterwards.
- 0x4F000000, then 0x7F800000. Expect 0x80000000 with invalid both times, `invalid_cnt`=2, then `flags_clr` → 0.
- All four requesters valid continuously with `out_ready`=1. Expect grants in order 0,1,2,3,0,..., and `out_id` following one cycle later.
- Hold `out_ready`=0 for 3 cycles with requests pending. Expect `req_ready`=0 and `out_int`/`out_id` frozen; release → one pop and one new load on the same edge.
- 0x00000001 (denormal) accepted on the same edge as `flags_clr`. Expect sticky_denorm=1, sticky_plost=1, `invalid_cnt`=0; asserting `rst_n`=0 mid-stream zeroes all outputs immediately.
